// File: rtl/list_sum_ctrl_if.sv
// Handshake and datapath-strobe bundle between the list-sum controller and its
// host/datapath side.
interface list_sum_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             NEXT_ZERO;
  logic             SUM_SEL;
  logic             NEXT_SEL;
  logic             A_SEL;
  logic             LD_SUM;
  logic             LD_NEXT;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] node_cnt;

  modport master (
    output start, NEXT_ZERO,
    input  SUM_SEL, NEXT_SEL, A_SEL, LD_SUM, LD_NEXT, busy, done, err, node_cnt
  );

  modport slave (
    input  start, NEXT_ZERO,
    output SUM_SEL, NEXT_SEL, A_SEL, LD_SUM, LD_NEXT, busy, done, err, node_cnt
  );
endinterface

// File: rtl/list_sum_ctrl.sv
// Control FSM for the linked-list summing datapath: clears SUM/NEXT, then
// alternates pointer fetch and value accumulate until a null pointer or the loop guard.
module list_sum_ctrl #(
  parameter int MAX_NODES = 8,
  parameter int CNT_W     = 5
) (
  input logic            clk,
  input logic            rst,
  list_sum_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FETCH,
    S_ACCUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NODES);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             at_limit;
  logic             take_node;

  assign at_limit  = (cnt == MAX_CNT);
  assign take_node = (state == S_FETCH) && !bus.NEXT_ZERO && !at_limit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter holds after DONE/ERR so the host can read the node count until the next walk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == S_INIT) begin
      cnt <= '0;
    end else if (take_node) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_INIT;
      S_INIT:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.NEXT_ZERO)  state_nxt = S_DONE;
        else if (at_limit)  state_nxt = S_ERR;
        else                state_nxt = S_ACCUM;
      end
      S_ACCUM: state_nxt = S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // LD_NEXT in FETCH is the only output that looks past the state register.
  always_comb begin
    bus.SUM_SEL  = 1'b0;
    bus.NEXT_SEL = 1'b0;
    bus.A_SEL    = 1'b0;
    bus.LD_SUM   = 1'b0;
    bus.LD_NEXT  = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    case (state)
      S_INIT: begin
        bus.LD_SUM  = 1'b1;
        bus.LD_NEXT = 1'b1;
        bus.busy    = 1'b1;
      end
      S_FETCH: begin
        bus.NEXT_SEL = 1'b1;
        bus.LD_NEXT  = take_node;
        bus.busy     = 1'b1;
      end
      S_ACCUM: begin
        bus.A_SEL   = 1'b1;
        bus.SUM_SEL = 1'b1;
        bus.LD_SUM  = 1'b1;
        bus.busy    = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      S_ERR: begin
        bus.done = 1'b1;
        bus.err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.node_cnt = cnt;

endmodule

// File: tb/tb_list_sum_ctrl.sv
// Bench for list_sum_ctrl: pairs the controller with a small datapath fixture and
// checks results and timing against a list-walking reference model.
module tb_list_sum_ctrl;

  localparam int MAX_NODES = 8;
  localparam int CNT_W     = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  list_sum_ctrl_if #(.CNT_W(CNT_W)) bus ();

  list_sum_ctrl #(
    .MAX_NODES(MAX_NODES),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Datapath fixture: memory, NEXT and SUM registers steered by the strobes.
  logic [31:0] mem [16];
  logic [31:0] next_reg;
  logic [31:0] sum_reg;
  logic [31:0] rd_data;
  logic [31:0] next_in;
  logic [3:0]  rd_addr;

  always_comb begin
    rd_addr = bus.A_SEL ? (next_reg[3:0] + 4'd1) : next_reg[3:0];
    rd_data = mem[rd_addr];
    next_in = bus.NEXT_SEL ? rd_data : 32'd0;
  end

  assign bus.NEXT_ZERO = (next_in == 32'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      next_reg <= '0;
      sum_reg  <= '0;
    end else begin
      if (bus.LD_NEXT) next_reg <= next_in;
      if (bus.LD_SUM)  sum_reg  <= bus.SUM_SEL ? (rd_data + sum_reg) : 32'd0;
    end
  end

  // Reference: follow pointers from mem[0], stopping at null or at the node limit.
  function automatic void model(output logic [31:0] s, output int n, output bit e);
    logic [3:0]  p;
    logic [3:0]  vaddr;
    logic [31:0] nxt;
    bit          stop;
    s = 32'd0;
    n = 0;
    e = 1'b0;
    p = 4'd0;
    stop = 1'b0;
    for (int g = 0; g <= MAX_NODES && !stop; g++) begin
      nxt = mem[p];
      if (nxt == 32'd0) begin
        stop = 1'b1;
      end else if (n == MAX_NODES) begin
        e = 1'b1;
        stop = 1'b1;
      end else begin
        n++;
        vaddr = nxt[3:0] + 4'd1;
        s = s + mem[vaddr];
        p = nxt[3:0];
      end
    end
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
  endtask

  task automatic load_two_node();
    clear_mem();
    mem[0] = 32'd2;
    mem[2] = 32'd5;
    mem[3] = 32'd10;
    mem[5] = 32'd0;
    mem[6] = 32'd7;
  endtask

  // Drives one walk and records what was observed; the calling test judges it.
  task automatic run_walk(input int exp_n, input bit pulse_fetch, input bit hold_start,
                          output int done_edge, output int busy_cycles,
                          output int strobe_bad, output bit err_seen);
    int edges;
    int fetch_idx;
    bit fin;
    edges       = 0;
    fin         = 1'b0;
    done_edge   = -1;
    busy_cycles = 0;
    strobe_bad  = 0;
    err_seen    = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = hold_start;
    while (!fin) begin
      @(negedge clk);
      if (pulse_fetch) bus.start = (edges == 1);
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_edge = edges;
        err_seen  = bus.err;
        fin       = 1'b1;
        if ({bus.SUM_SEL, bus.NEXT_SEL, bus.A_SEL, bus.LD_SUM, bus.LD_NEXT} !== 5'b0)
          strobe_bad++;
      end else if (edges == 0) begin
        if ({bus.SUM_SEL, bus.NEXT_SEL, bus.LD_SUM, bus.LD_NEXT} !== 4'b0011) strobe_bad++;
      end else if (edges % 2 == 1) begin
        fetch_idx = (edges - 1) / 2;
        if (bus.NEXT_SEL !== 1'b1 || bus.A_SEL !== 1'b0 || bus.LD_SUM !== 1'b0 ||
            bus.LD_NEXT !== 1'(fetch_idx < exp_n))
          strobe_bad++;
      end else begin
        if ({bus.A_SEL, bus.SUM_SEL, bus.LD_SUM, bus.LD_NEXT, bus.NEXT_SEL} !== 5'b11100)
          strobe_bad++;
      end
      if (!fin) begin
        if (edges >= 60) begin
          fin = 1'b1;
          $display("[TB] walk did not finish within 60 cycles");
        end else begin
          @(posedge clk);
          edges++;
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.SUM_SEL, bus.NEXT_SEL, bus.A_SEL, bus.LD_SUM, bus.LD_NEXT, bus.busy, bus.done,
         bus.err, bus.node_cnt} !== {8'b0, CNT_W'(0)})
      $display("[TB] FAIL reset_outputs: got %b node_cnt %0d, expected all zero",
               {bus.SUM_SEL, bus.NEXT_SEL, bus.A_SEL, bus.LD_SUM, bus.LD_NEXT, bus.busy,
                bus.done, bus.err}, bus.node_cnt);
    else passed++;
    rst = 1'b1;
  endtask

  // Runs a walk on the current memory and checks every observable against the model.
  task automatic test_walk(input string name, input bit pulse_fetch);
    logic [31:0] exp_sum;
    int          exp_n;
    bit          exp_err;
    int          done_edge, busy_cycles, strobe_bad;
    bit          err_seen;
    model(exp_sum, exp_n, exp_err);
    run_walk(exp_n, pulse_fetch, 1'b0, done_edge, busy_cycles, strobe_bad, err_seen);
    total++;
    if (done_edge != 2 * exp_n + 2)
      $display("[TB] FAIL %s_done_edge: got %0d expected %0d", name, done_edge, 2 * exp_n + 2);
    else passed++;
    total++;
    if (busy_cycles != 2 * exp_n + 2)
      $display("[TB] FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cycles, 2 * exp_n + 2);
    else passed++;
    total++;
    if (sum_reg !== exp_sum)
      $display("[TB] FAIL %s_sum: got %0d expected %0d", name, sum_reg, exp_sum);
    else passed++;
    total++;
    if (bus.node_cnt !== CNT_W'(exp_n) || err_seen !== exp_err)
      $display("[TB] FAIL %s_cnt_err: got cnt %0d err %0b expected cnt %0d err %0b",
               name, bus.node_cnt, err_seen, exp_n, exp_err);
    else passed++;
    total++;
    if (strobe_bad != 0)
      $display("[TB] FAIL %s_strobes: got %0d bad cycles expected 0", name, strobe_bad);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.node_cnt !== CNT_W'(exp_n))
      $display("[TB] FAIL %s_after_done: got done %0b err %0b cnt %0d expected 0 0 %0d",
               name, bus.done, bus.err, bus.node_cnt, exp_n);
    else passed++;
  endtask

  task automatic test_two_node();
    load_two_node();
    test_walk("two_node", 1'b0);
  endtask

  task automatic test_empty();
    clear_mem();
    test_walk("empty", 1'b0);
  endtask

  task automatic test_cyclic();
    clear_mem();
    mem[0] = 32'd2;
    mem[2] = 32'd2;
    mem[3] = 32'd3;
    test_walk("cyclic", 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0)      mem[i] = 32'd0;
        else if ($urandom_range(0, 5) == 0) mem[i] = $urandom;
        else                                mem[i] = 32'($urandom_range(1, 15));
      end
      test_walk($sformatf("random%0d", it), 1'b0);
    end
  endtask

  task automatic test_reset_mid_walk();
    load_two_node();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.A_SEL !== 1'b1 || bus.LD_SUM !== 1'b1)
      $display("[TB] FAIL midwalk_in_accum: got A_SEL %0b LD_SUM %0b expected 1 1",
               bus.A_SEL, bus.LD_SUM);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.SUM_SEL, bus.NEXT_SEL, bus.A_SEL, bus.LD_SUM, bus.LD_NEXT, bus.busy, bus.done,
         bus.err, bus.node_cnt} !== {8'b0, CNT_W'(0)})
      $display("[TB] FAIL midwalk_reset: got %b node_cnt %0d expected all zero",
               {bus.SUM_SEL, bus.NEXT_SEL, bus.A_SEL, bus.LD_SUM, bus.LD_NEXT, bus.busy,
                bus.done, bus.err}, bus.node_cnt);
    else passed++;
    rst = 1'b1;
    test_walk("after_reset", 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_sum;
    int          exp_n;
    bit          exp_err;
    int          done_edge, busy_cycles, strobe_bad, k;
    bit          err_seen;
    bit          idle_ok;
    load_two_node();
    test_walk("start_in_fetch", 1'b1);
    idle_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) idle_ok = 1'b0;
    end
    total++;
    if (!idle_ok) $display("[TB] FAIL ignored_start: got activity after walk expected idle");
    else passed++;

    model(exp_sum, exp_n, exp_err);
    run_walk(exp_n, 1'b0, 1'b1, done_edge, busy_cycles, strobe_bad, err_seen);
    total++;
    if (done_edge != 2 * exp_n + 2 || sum_reg !== exp_sum)
      $display("[TB] FAIL held_first: got edge %0d sum %0d expected %0d %0d",
               done_edge, sum_reg, 2 * exp_n + 2, exp_sum);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("[TB] FAIL held_idle: got busy %0b done %0b expected 0 0", bus.busy, bus.done);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1 || bus.LD_SUM !== 1'b1 || bus.LD_NEXT !== 1'b1 || bus.NEXT_SEL !== 1'b0)
      $display("[TB] FAIL held_init: got busy %0b LD_SUM %0b LD_NEXT %0b NEXT_SEL %0b expected 1 1 1 0",
               bus.busy, bus.LD_SUM, bus.LD_NEXT, bus.NEXT_SEL);
    else passed++;
    bus.start = 1'b0;
    k = 0;
    while (bus.done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (bus.done !== 1'b1 || k != 2 * exp_n + 2 || sum_reg !== exp_sum)
      $display("[TB] FAIL held_second: got done %0b edge %0d sum %0d expected 1 %0d %0d",
               bus.done, k, sum_reg, 2 * exp_n + 2, exp_sum);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    clear_mem();
    test_reset();
    test_two_node();
    test_empty();
    test_cyclic();
    test_reset_mid_walk();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/list_sum_ctrl.md
# list_sum_ctrl

Control FSM that sequences the 32-bit linked-list summing datapath. It drives the datapath's five control strobes (SUM_SEL, NEXT_SEL, A_SEL, LD_SUM, LD_NEXT) and consumes NEXT_ZERO, then walks the list in datapath memory until it reaches a null pointer. A start/done handshake, a node counter and a loop guard make a complete summing unit when the block is paired with the datapath. The sum itself stays in the datapath SUM register (sum_out).

## Interface
Parameters:
- MAX_NODES, default 8: maximum nodes accepted before the walk is declared cyclic.
- CNT_W, default 5: width of node_cnt; must satisfy 2^CNT_W > MAX_NODES.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset. Shared with the datapath.
- start  in  1  request a walk; sampled only in IDLE.
- NEXT_ZERO  in  1  from datapath: NEXT_IN == 0.
- SUM_SEL  out  1  0: SUM input = 0; 1: SUM input = data + sum_out.
- NEXT_SEL  out  1  0: NEXT input = 0; 1: NEXT input = memory data.
- A_SEL  out  1  0: read address = NEXT; 1: read address = NEXT + 1.
- LD_SUM  out  1  SUM register load enable.
- LD_NEXT  out  1  NEXT register load enable.
- busy  out  1  high from INIT through the last FETCH/ACCUM.
- done  out  1  one-cycle pulse; walk finished, sum_out valid.
- err  out  1  one-cycle pulse coincident with done; loop guard hit.
- node_cnt  out  CNT_W  nodes accumulated in the current/last walk.

## Operation
- List format: mem[0] = head pointer. For a node at address p, mem[p] = next pointer and mem[p+1] = value. Pointer 0 terminates the list. Addresses are 4 bits, and p+1 wraps modulo 16 inside the datapath.
- States: IDLE, INIT, FETCH, ACCUM, DONE, ERR. Encoding is free.
- IDLE: all strobes 0, busy 0. If start=1, go to INIT; otherwise stay.
- INIT: SUM_SEL=0, NEXT_SEL=0, LD_SUM=1, LD_NEXT=1, so SUM and NEXT are cleared. node_cnt is cleared to 0. busy=1. Go to FETCH.
- FETCH: NEXT_SEL=1, A_SEL=0, LD_SUM=0. busy=1.
  - If NEXT_ZERO=1: LD_NEXT=0, go to DONE.
  - Else if node_cnt == MAX_NODES: LD_NEXT=0, go to ERR.
  - Else: LD_NEXT=1, node_cnt+1, go to ACCUM.
  - LD_NEXT is the only Mealy output (it depends on NEXT_ZERO and node_cnt). All other outputs decode from state only.
- ACCUM: A_SEL=1, SUM_SEL=1, LD_SUM=1, LD_NEXT=0, NEXT_SEL=0. busy=1. Go to FETCH.
- DONE: done=1, all strobes 0, busy=0. Go to IDLE unconditionally.
- ERR: done=1, err=1, all strobes 0, busy=0. Go to IDLE. SUM holds the sum of the first MAX_NODES values.
- node_cnt holds its value after DONE/ERR until the next INIT.
- Arithmetic: node_cnt is an unsigned counter. It cannot overflow because the guard stops it at MAX_NODES. Sum overflow wraps modulo 2^32 in the datapath and is not flagged.
- start is ignored in every state except IDLE. If start is held high, a new walk begins in the cycle after DONE/ERR.

## Timing
- Reset (rst=0 at an edge): state becomes IDLE. All strobes, busy, done and err are 0, and node_cnt is 0. This holds mid-walk too; the partial sum is discarded because the datapath resets with the same rst.
- Let E0 be the edge that samples start=1 in IDLE. State is INIT after E0.
- For a list of N nodes, with N ≤ MAX_NODES:
  - The state is DONE in the cycle after edge E0 + 2N + 2.
  - done is high exactly one cycle.
  - busy is high for 2N + 2 cycles.
- For a cyclic or too-long list, the state is ERR after edge E0 + 2·MAX_NODES + 2.
- Minimum start-to-start period for an empty list is 4 cycles: IDLE sample, INIT, FETCH, DONE.

## Test plan
- Two-node list: mem[0]=2, mem[2]=5, mem[3]=10, mem[5]=0, mem[6]=7, start pulse at E0 → done after E0+6, sum_out=17, node_cnt=2, err=0, busy high 6 cycles.
- Empty list: mem[0]=0, start → done after E0+2, sum_out=0, node_cnt=0, LD_NEXT never asserted in FETCH.
- Cyclic list: mem[0]=2, mem[2]=2, mem[3]=3, MAX_NODES=8 → done=err=1 after E0+18, sum_out=24, node_cnt=8.
- Reset mid-walk: run the two-node list and drive rst=0 during the first ACCUM → next cycle all outputs 0, state IDLE. After rst=1 and a new start, the result is again 17.
- Start during busy plus held start: pulse start in FETCH → no effect. Then hold start=1 through DONE → second walk's INIT begins 2 cycles after the first done, with the same result.
- Strobe check: in every FETCH cycle assert LD_SUM=0 and NEXT_SEL=1. In every ACCUM cycle assert LD_NEXT=0 and A_SEL=1. Outside INIT/FETCH/ACCUM assert all strobes are 0.
